gaussian_blur_stream: RTL and testbench

//  Streaming 3x3 Gaussian blur with kernel 1-2-1 / 2-4-2 / 1-2-1 and a divide by 16.

---
 rtl/gaussian_blur_stream.sv | 217 +++++++++++++++++++++
 tb/tb_gaussian_blur_stream.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_blur_stream.sv
// ---------------------------------------------------------------------------
// gaussian_blur_stream
//
// Streaming 3x3 Gaussian blur (kernel 1-2-1 / 2-4-2 / 1-2-1, divide by 16).
// Raster-order pixels enter one per cycle over valid/ready. Two line RAMs
// hold the previous two lines. Each interior centre pixel is emitted through
// a single output register that also uses valid/ready.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_valid/ready  input handshake; a pixel is taken on in_valid && in_ready
//   in_data         input pixel, unsigned DATA_W bits
//   in_sof          marks pixel (0,0) and forces the counters to restart
//   out_valid/ready output handshake
//   out_data        blurred centre pixel
//   out_row/col     coordinates of the centre pixel (1..IMG_H-2 / 1..IMG_W-2)
//   out_sof         high with centre (1,1)
//   out_eol         high with centre column IMG_W-2
// ---------------------------------------------------------------------------
module gaussian_blur_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ROUND  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_sof,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic                       out_sof,
  output logic                       out_eol
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int SUM_W = DATA_W + 4;

  // Weighted taps, zero-extended to the full sum width.
  function automatic logic [SUM_W-1:0] tap_x1(input logic [DATA_W-1:0] p);
    return {4'b0000, p};
  endfunction

  function automatic logic [SUM_W-1:0] tap_x2(input logic [DATA_W-1:0] p);
    return {3'b000, p, 1'b0};
  endfunction

  function automatic logic [SUM_W-1:0] tap_x4(input logic [DATA_W-1:0] p);
    return {2'b00, p, 2'b00};
  endfunction

  // Full kernel sum; the maximum is 16*(2^DATA_W-1), which fits SUM_W bits.
  function automatic logic [SUM_W-1:0] kernel_sum(
    input logic [DATA_W-1:0] tl, input logic [DATA_W-1:0] tc, input logic [DATA_W-1:0] tr,
    input logic [DATA_W-1:0] ml, input logic [DATA_W-1:0] mc, input logic [DATA_W-1:0] mr,
    input logic [DATA_W-1:0] bl, input logic [DATA_W-1:0] bc, input logic [DATA_W-1:0] br
  );
    return tap_x1(tl) + tap_x2(tc) + tap_x1(tr)
         + tap_x2(ml) + tap_x4(mc) + tap_x2(mr)
         + tap_x1(bl) + tap_x2(bc) + tap_x1(br);
  endfunction

  // Divide by 16 with optional round-half-up. Adding 8 to a sum of at most
  // 16*(2^DATA_W-1) still fits SUM_W bits, so no saturation is required.
  function automatic logic [DATA_W-1:0] round_div16(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] t;
    t = s + ((ROUND != 0) ? SUM_W'(8) : SUM_W'(0));
    return t[SUM_W-1:4];
  endfunction

  // Control state
  logic                 rdy_en_q, rdy_en_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;

  // Window: [row][col], row 0 = line r-2, row 2 = current line; col 2 newest.
  logic [DATA_W-1:0]    win_q [3][3];
  logic [DATA_W-1:0]    win_d [3][3];

  // Line RAMs: lb1 holds line r-1, lb2 holds line r-2, both indexed by column.
  logic [DATA_W-1:0]    lb1_mem [IMG_W];
  logic [DATA_W-1:0]    lb2_mem [IMG_W];
  logic [DATA_W-1:0]    lb1_rd, lb2_rd;

  // Output register
  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [ROW_W-1:0]     out_row_q, out_row_d;
  logic [COL_W-1:0]     out_col_q, out_col_d;
  logic                 out_sof_q, out_sof_d;
  logic                 out_eol_q, out_eol_d;

  // Handshake / position decode
  logic                 accept;
  logic                 emit;
  logic                 last_col;
  logic [COL_W-1:0]     col_eff;
  logic [ROW_W-1:0]     row_eff;

  // rdy_en_q keeps in_ready low during reset and releases it one edge later.
  assign rdy_en_d  = 1'b1;
  assign in_ready  = rdy_en_q && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;

  // in_sof overrides whatever position the counters currently hold.
  assign col_eff   = in_sof ? '0 : col_q;
  assign row_eff   = in_sof ? '0 : row_q;
  assign last_col  = (col_eff == COL_W'(IMG_W - 1));
  assign emit      = accept && (row_eff >= ROW_W'(2)) && (col_eff >= COL_W'(2));

  assign lb1_rd    = lb1_mem[col_eff];
  assign lb2_rd    = lb2_mem[col_eff];

  // ---- Stage: input position counters ----
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = (row_eff == ROW_W'(IMG_H - 1)) ? '0 : row_eff + ROW_W'(1);
      end else begin
        col_d = col_eff + COL_W'(1);
        row_d = row_eff;
      end
    end
  end

  // ---- Stage: window shift ----
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = in_data;
    end
  end

  // ---- Stage: kernel and output register ----
  // The sum uses the post-shift window: old columns 1 and 2 plus the new column.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_sof_d   = out_sof_q;
    out_eol_d   = out_eol_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = round_div16(kernel_sum(
                      win_q[0][1], win_q[0][2], lb2_rd,
                      win_q[1][1], win_q[1][2], lb1_rd,
                      win_q[2][1], win_q[2][2], in_data));
      out_row_d   = row_eff - ROW_W'(1);
      out_col_d   = col_eff - COL_W'(1);
      out_sof_d   = (row_eff == ROW_W'(2)) && (col_eff == COL_W'(2));
      out_eol_d   = last_col;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en_q    <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      rdy_en_q    <= rdy_en_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
    end
  end

  // Line RAM update: the r-1 line moves down to r-2 and the new pixel
  // becomes the r-1 line at this column. Contents need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2_mem[col_eff] <= lb1_rd;
      lb1_mem[col_eff] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;

endmodule

// File: tb/tb_gaussian_blur_stream.sv
module tb_gaussian_blur_stream;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_sof, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, out_sof, out_eol;
  logic [DW-1:0] out_data;
  logic [2:0]    out_row, out_col;
  logic          in_ready_t, out_valid_t, out_sof_t, out_eol_t;
  logic [DW-1:0] out_data_t;
  logic [2:0]    out_row_t, out_col_t;

  gaussian_blur_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .ROUND(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .out_sof(out_sof), .out_eol(out_eol)
  );

  // Truncating twin fed with identical stimulus.
  gaussian_blur_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .ROUND(0)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
    .in_data(in_data), .in_sof(in_sof), .out_valid(out_valid_t),
    .out_ready(out_ready), .out_data(out_data_t), .out_row(out_row_t),
    .out_col(out_col_t), .out_sof(out_sof_t), .out_eol(out_eol_t)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int dt;
    int r;
    int c;
    int s;
    int e;
  } obs_t;

  int   checks = 0;
  int   errors = 0;
  int   img [2][8][8];
  int   stim_d [0:127];
  bit   stim_s [0:127];
  int   stall_lo = -1;
  int   stall_hi = -1;
  int   rdy_at_stall_start = -1;
  int   rdy_at_stall_end = -1;
  int   cyc_used = 0;
  obs_t oq [$];

  // Record every output transfer, sampled mid-cycle.
  always @(negedge clk) begin
    obs_t o;
    if (!rst && out_valid && out_ready) begin
      o.d  = int'(out_data);
      o.dt = int'(out_data_t);
      o.r  = int'(out_row);
      o.c  = int'(out_col);
      o.s  = int'(out_sof);
      o.e  = int'(out_eol);
      oq.push_back(o);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Frame-level reference: direct 3x3 convolution over the stored image.
  function automatic int blur_ref(input int k, input int r, input int c, input int rnd);
    int wt [3][3];
    int s;
    wt[0][0] = 1; wt[0][1] = 2; wt[0][2] = 1;
    wt[1][0] = 2; wt[1][1] = 4; wt[1][2] = 2;
    wt[2][0] = 1; wt[2][1] = 2; wt[2][2] = 1;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += wt[i][j] * img[k][r-1+i][c-1+j];
    return (s + (rnd != 0 ? 8 : 0)) / 16;
  endfunction

  task automatic load_img(input int k, input int base, input bit sof0);
    for (int idx = 0; idx < 64; idx++) begin
      stim_d[base+idx] = img[k][idx/8][idx%8];
      stim_s[base+idx] = (idx == 0) && sof0;
    end
  endtask

  task automatic run_pixels(input int n);
    int i;
    int cyc;
    bit acc;
    i = 0;
    cyc = 0;
    while (i < n && cyc < 1000) begin
      in_valid  = 1'b1;
      in_data   = 8'(stim_d[i]);
      in_sof    = stim_s[i];
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      @(negedge clk);
      if (cyc == stall_lo) rdy_at_stall_start = int'(in_ready);
      if (cyc == stall_hi) rdy_at_stall_end   = int'(in_ready);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      cyc++;
    end
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    cyc_used  = cyc;
    checks++;
    if (i !== n) begin
      errors++;
      $display("FAIL run_pixels accepted %0d pixels, required %0d", i, n);
    end
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    end
    checks++;
    if (out_data !== 8'd0 || out_sof !== 1'b0 || out_eol !== 1'b0 || out_row !== 3'd0 || out_col !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs data=%0d sof=%b eol=%b row=%0d col=%0d required all 0",
               out_data, out_sof, out_eol, out_row, out_col);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_early in_ready=%b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_constant();
    int n;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        img[0][r][c] = 100;
    load_img(0, 0, 1'b1);
    oq.delete();
    run_pixels(64);
    drain();
    checks++;
    if (cyc_used !== 64) begin
      errors++;
      $display("FAIL const_throughput cycles=%0d required 64", cyc_used);
    end
    checks++;
    if (oq.size() !== 36) begin
      errors++;
      $display("FAIL const_count outputs=%0d required 36", oq.size());
    end
    n = (oq.size() < 36) ? oq.size() : 36;
    for (int j = 0; j < n; j++) begin
      int er, ec, es, ee;
      er = 1 + j / 6; ec = 1 + j % 6;
      es = (er == 1 && ec == 1) ? 1 : 0;
      ee = (ec == 6) ? 1 : 0;
      checks++;
      if (oq[j].d !== 100 || oq[j].dt !== 100 || oq[j].r !== er || oq[j].c !== ec ||
          oq[j].s !== es || oq[j].e !== ee) begin
        errors++;
        $display("FAIL const_out[%0d] got d=%0d dt=%0d (%0d,%0d) sof=%0d eol=%0d required d=100 dt=100 (%0d,%0d) sof=%0d eol=%0d",
                 j, oq[j].d, oq[j].dt, oq[j].r, oq[j].c, oq[j].s, oq[j].e, er, ec, es, ee);
      end
    end
  endtask

  task automatic test_impulse();
    int n;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        img[0][r][c] = 0;
    img[0][4][4] = 255;
    load_img(0, 0, 1'b1);
    oq.delete();
    run_pixels(64);
    drain();
    checks++;
    if (oq.size() !== 36) begin
      errors++;
      $display("FAIL impulse_count outputs=%0d required 36", oq.size());
    end
    n = (oq.size() < 36) ? oq.size() : 36;
    for (int j = 0; j < n; j++) begin
      int er, ec, dr, dc, e1, e0;
      er = 1 + j / 6; ec = 1 + j % 6;
      dr = (er > 4) ? er - 4 : 4 - er;
      dc = (ec > 4) ? ec - 4 : 4 - ec;
      if (dr == 0 && dc == 0)      begin e1 = 64; e0 = 63; end
      else if (dr + dc == 1)       begin e1 = 32; e0 = 31; end
      else if (dr == 1 && dc == 1) begin e1 = 16; e0 = 15; end
      else                         begin e1 = 0;  e0 = 0;  end
      checks++;
      if (oq[j].d !== e1 || oq[j].dt !== e0 || oq[j].r !== er || oq[j].c !== ec) begin
        errors++;
        $display("FAIL impulse_out[%0d] got round=%0d trunc=%0d at (%0d,%0d) required %0d %0d at (%0d,%0d)",
                 j, oq[j].d, oq[j].dt, oq[j].r, oq[j].c, e1, e0, er, ec);
      end
    end
  endtask

  task automatic test_ramp();
    int n;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        img[0][r][c] = c * 10;
    load_img(0, 0, 1'b1);
    oq.delete();
    run_pixels(64);
    drain();
    checks++;
    if (oq.size() !== 36) begin
      errors++;
      $display("FAIL ramp_count outputs=%0d required 36", oq.size());
    end
    n = (oq.size() < 36) ? oq.size() : 36;
    for (int j = 0; j < n; j++) begin
      int ec;
      ec = 1 + j % 6;
      checks++;
      if (oq[j].c !== ec || oq[j].d !== ec * 10 || oq[j].dt !== ec * 10) begin
        errors++;
        $display("FAIL ramp_out[%0d] got col=%0d d=%0d dt=%0d required col=%0d d=%0d",
                 j, oq[j].c, oq[j].d, oq[j].dt, ec, ec * 10);
      end
    end
  endtask

  task automatic test_stall();
    int n;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        img[0][r][c] = (r * 37 + c * 59 + r * c * 13) % 256;
    load_img(0, 0, 1'b1);
    oq.delete();
    stall_lo = 30; stall_hi = 39;
    run_pixels(64);
    stall_lo = -1; stall_hi = -1;
    drain();
    checks++;
    if (rdy_at_stall_start !== 0 || rdy_at_stall_end !== 0) begin
      errors++;
      $display("FAIL stall_in_ready first=%0d last=%0d required 0 0", rdy_at_stall_start, rdy_at_stall_end);
    end
    checks++;
    if (cyc_used !== 74) begin
      errors++;
      $display("FAIL stall_cycles cycles=%0d required 74", cyc_used);
    end
    checks++;
    if (oq.size() !== 36) begin
      errors++;
      $display("FAIL stall_count outputs=%0d required 36", oq.size());
    end
    n = (oq.size() < 36) ? oq.size() : 36;
    for (int j = 0; j < n; j++) begin
      int er, ec, e1, e0;
      er = 1 + j / 6; ec = 1 + j % 6;
      e1 = blur_ref(0, er, ec, 1);
      e0 = blur_ref(0, er, ec, 0);
      checks++;
      if (oq[j].d !== e1 || oq[j].dt !== e0 || oq[j].r !== er || oq[j].c !== ec) begin
        errors++;
        $display("FAIL stall_out[%0d] got %0d/%0d at (%0d,%0d) required %0d/%0d at (%0d,%0d)",
                 j, oq[j].d, oq[j].dt, oq[j].r, oq[j].c, e1, e0, er, ec);
      end
    end
  endtask

  task automatic test_sof_mid();
    int n;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        img[0][r][c] = (r * 19 + c * 23) % 256;
        img[1][r][c] = (200 - r * 11 + c * c * 3) % 256;
      end
    load_img(0, 0, 1'b1);
    load_img(1, 20, 1'b1);
    oq.delete();
    run_pixels(84);
    drain();
    checks++;
    if (oq.size() !== 38) begin
      errors++;
      $display("FAIL sof_count outputs=%0d required 38", oq.size());
    end
    if (oq.size() >= 2) begin
      checks++;
      if (oq[0].d !== blur_ref(0, 1, 1, 1) || oq[0].s !== 1 ||
          oq[1].d !== blur_ref(0, 1, 2, 1) || oq[1].s !== 0 || oq[1].c !== 2) begin
        errors++;
        $display("FAIL sof_old_frame got %0d sof=%0d, %0d sof=%0d col=%0d required %0d 1, %0d 0 2",
                 oq[0].d, oq[0].s, oq[1].d, oq[1].s, oq[1].c, blur_ref(0, 1, 1, 1), blur_ref(0, 1, 2, 1));
      end
    end
    n = (oq.size() < 38) ? oq.size() : 38;
    for (int j = 2; j < n; j++) begin
      int er, ec, es;
      er = 1 + (j - 2) / 6; ec = 1 + (j - 2) % 6;
      es = (j == 2) ? 1 : 0;
      checks++;
      if (oq[j].d !== blur_ref(1, er, ec, 1) || oq[j].dt !== blur_ref(1, er, ec, 0) ||
          oq[j].r !== er || oq[j].c !== ec || oq[j].s !== es) begin
        errors++;
        $display("FAIL sof_new[%0d] got %0d/%0d (%0d,%0d) sof=%0d required %0d/%0d (%0d,%0d) sof=%0d",
                 j, oq[j].d, oq[j].dt, oq[j].r, oq[j].c, oq[j].s,
                 blur_ref(1, er, ec, 1), blur_ref(1, er, ec, 0), er, ec, es);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        img[0][r][c] = (r * 71 + c * 5 + 9) % 256;
        img[1][r][c] = (r * c * 7 + r * 29 + c * 41) % 256;
      end
    load_img(0, 0, 1'b1);
    run_pixels(30);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_held out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    oq.delete();
    load_img(1, 0, 1'b0);
    run_pixels(64);
    drain();
    checks++;
    if (oq.size() !== 36) begin
      errors++;
      $display("FAIL mid_reset_count outputs=%0d required 36", oq.size());
    end
    n = (oq.size() < 36) ? oq.size() : 36;
    for (int j = 0; j < n; j++) begin
      int er, ec, es;
      er = 1 + j / 6; ec = 1 + j % 6;
      es = (j == 0) ? 1 : 0;
      checks++;
      if (oq[j].d !== blur_ref(1, er, ec, 1) || oq[j].r !== er || oq[j].c !== ec || oq[j].s !== es) begin
        errors++;
        $display("FAIL mid_reset_out[%0d] got %0d (%0d,%0d) sof=%0d required %0d (%0d,%0d) sof=%0d",
                 j, oq[j].d, oq[j].r, oq[j].c, oq[j].s, blur_ref(1, er, ec, 1), er, ec, es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_impulse();
    test_ramp();
    test_stall();
    test_sof_mid();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
